// File: rtl/mgmt_readback_tx_pkg.sv
// -----------------------------------------------------------------------------
// mgmt_readback_tx_pkg
//
// Shared definitions for the management SPI interface: command opcodes,
// the serial receive/transmit state encoding and the configuration
// register address map.  The SPI configuration slave and the readback
// transmitter both import this package, so opcodes and addresses stay
// consistent between the two.
// -----------------------------------------------------------------------------
package mgmt_readback_tx_pkg;

  // Command opcodes (first byte of every transaction)
  localparam logic [7:0] CMD_READ       = 8'h03;  // single register read
  localparam logic [7:0] CMD_BURST_READ = 8'h0B;  // auto-incrementing read

  // Serial engine states.  Kept as plain constants so that legacy code
  // comparing against raw 3-bit values continues to work.
  typedef logic [2:0] mgmt_state_t;

  localparam mgmt_state_t ST_CMD    = 3'd0;
  localparam mgmt_state_t ST_ADDR   = 3'd1;
  localparam mgmt_state_t ST_DUMMY  = 3'd2;
  localparam mgmt_state_t ST_SHIFT  = 3'd3;
  localparam mgmt_state_t ST_IGNORE = 3'd4;

  // Register address map: a contiguous block starting at 0x00.
  localparam logic [7:0] REG_ADDR_FIRST = 8'h00;
  localparam logic [7:0] REG_ADDR_LAST  = 8'h0D;
  localparam int         MGMT_NUM_REGS  = int'(REG_ADDR_LAST) + 1;

  // Next burst address.  The last implemented register wraps back to the
  // first one; any address beyond the map simply counts up and rolls over
  // naturally at 0xFF.
  function automatic logic [7:0] next_rd_addr(input logic [7:0] addr,
                                              input logic [7:0] last_addr);
    if (addr == last_addr) begin
      return REG_ADDR_FIRST;
    end
    return addr + 8'd1;
  endfunction

endpackage

// File: rtl/mgmt_readback_tx.sv
// -----------------------------------------------------------------------------
// mgmt_readback_tx
//
// Read side of the management SPI slave.  Receives a command byte, an
// address byte and DUMMY_BYTES turnaround bytes on mgmt_mosi, then returns
// register contents on mgmt_miso, MSB first.  Command 0x03 returns a single
// register followed by zero bytes; command 0x0B returns consecutive
// registers until chip select is released.  The register file itself lives
// outside: this block presents rd_addr and samples rd_data combinationally.
//
// Timing: all flops use the rising edge of mgmt_clk_or_mgmt_cs_n.  A MISO
// bit changes on a rising edge and is held until the next one, so the host
// samples on the falling edge.  The MSB of the first data byte appears
// after rising edge 8*(2+DUMMY_BYTES).
//
// Ports
//   mgmt_clk_or_mgmt_cs_n  in   block clock (rising edge)
//   rst                    in   asynchronous active-high reset
//   mgmt_cs_n              in   chip select level, active low; an edge seen
//                               with mgmt_cs_n=1 aborts/ends the transaction
//   mgmt_mosi              in   serial command/address, MSB first
//   mgmt_miso              out  serial read data, MSB first
//   rd_addr[7:0]           out  registered register-file read address
//   rd_data[7:0]           in   register-file value at rd_addr
//   rd_en                  out  one-clock pulse when rd_data is captured
//   byte_count[7:0]        out  data bytes loaded this/last transaction,
//                               saturating at 0xFF
//   cmd_error              out  unsupported command seen (sticky until the
//                               next transaction starts)
//
// Parameters
//   NUM_REGS     number of readable registers at 0x00..NUM_REGS-1
//   DUMMY_BYTES  turnaround bytes between address and data (1..3)
// -----------------------------------------------------------------------------
module mgmt_readback_tx
  import mgmt_readback_tx_pkg::*;
#(
  parameter int NUM_REGS    = MGMT_NUM_REGS,
  parameter int DUMMY_BYTES = 1
) (
  input  logic       mgmt_clk_or_mgmt_cs_n,
  input  logic       rst,
  input  logic       mgmt_cs_n,
  input  logic       mgmt_mosi,
  output logic       mgmt_miso,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       rd_en,
  output logic [7:0] byte_count,
  output logic       cmd_error
);

  // 9-bit compare width so that NUM_REGS=256 (every address valid) works.
  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [7:0] LAST_ADDR  = 8'(NUM_REGS - 1);
  localparam logic [1:0] DUMMY_LAST = 2'(DUMMY_BYTES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mgmt_state_t state_q,      state_d;
  logic [2:0]  bit_cnt_q,    bit_cnt_d;
  logic [6:0]  rx_shift_q,   rx_shift_d;    // the 8th bit comes straight from mosi
  logic [1:0]  dummy_cnt_q,  dummy_cnt_d;
  logic        burst_q,      burst_d;
  logic [7:0]  tx_shift_q,   tx_shift_d;
  logic [7:0]  rd_addr_q,    rd_addr_d;
  logic        rd_en_q,      rd_en_d;
  logic [7:0]  byte_count_q, byte_count_d;
  logic        cmd_error_q,  cmd_error_d;

  // Combinational helpers
  logic [7:0]  rx_byte;
  logic        byte_done;
  logic        addr_in_range;
  logic [7:0]  rd_value;
  logic        load_data;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    dummy_cnt_d  = dummy_cnt_q;
    burst_d      = burst_q;
    tx_shift_d   = tx_shift_q;
    rd_addr_d    = rd_addr_q;
    rd_en_d      = 1'b0;
    byte_count_d = byte_count_q;
    cmd_error_d  = cmd_error_q;
    load_data    = 1'b0;

    // The byte completing on this edge includes the bit being sampled now.
    rx_byte       = {rx_shift_q, mgmt_mosi};
    byte_done     = (bit_cnt_q == 3'd7);
    addr_in_range = ({1'b0, rd_addr_q} < NUM_REGS_W);
    rd_value      = addr_in_range ? rd_data : 8'hFF;

    if (mgmt_cs_n) begin
      // CS-release edge: drop any partial byte and return to idle.  The
      // status outputs are deliberately kept so software can read them
      // after the transaction.
      state_d     = ST_CMD;
      bit_cnt_d   = 3'd0;
      rx_shift_d  = 7'd0;
      dummy_cnt_d = 2'd0;
      tx_shift_d  = 8'h00;
    end else begin
      bit_cnt_d  = bit_cnt_q + 3'd1;
      rx_shift_d = rx_byte[6:0];

      // First edge of a new transaction clears the previous status.
      if ((state_q == ST_CMD) && (bit_cnt_q == 3'd0)) begin
        byte_count_d = 8'h00;
        cmd_error_d  = 1'b0;
      end

      case (state_q)
        ST_CMD: begin
          if (byte_done) begin
            if (rx_byte == CMD_READ) begin
              state_d = ST_ADDR;
              burst_d = 1'b0;
            end else if (rx_byte == CMD_BURST_READ) begin
              state_d = ST_ADDR;
              burst_d = 1'b1;
            end else begin
              state_d     = ST_IGNORE;
              cmd_error_d = 1'b1;
            end
          end
        end

        ST_ADDR: begin
          if (byte_done) begin
            rd_addr_d   = rx_byte;
            dummy_cnt_d = 2'd0;
            state_d     = ST_DUMMY;
          end
        end

        ST_DUMMY: begin
          if (byte_done) begin
            if (dummy_cnt_q == DUMMY_LAST) begin
              // rd_addr has been stable for a full byte, so rd_data is
              // settled and the first data byte can be captured here.
              state_d   = ST_SHIFT;
              load_data = 1'b1;
            end else begin
              dummy_cnt_d = dummy_cnt_q + 2'd1;
            end
          end
        end

        ST_SHIFT: begin
          if (byte_done) begin
            if (burst_q) begin
              load_data = 1'b1;
            end else begin
              // Single read: only the first byte carries data.
              tx_shift_d = 8'h00;
            end
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end

        ST_IGNORE: begin
          // Unsupported command: consume bits silently until CS release.
        end

        default: begin
          state_d = ST_CMD;
        end
      endcase

      if (load_data) begin
        tx_shift_d   = rd_value;
        rd_en_d      = 1'b1;
        byte_count_d = (byte_count_q == 8'hFF) ? 8'hFF : byte_count_q + 8'd1;
        // Single reads leave rd_addr on the requested register.
        if (burst_q) begin
          rd_addr_d = next_rd_addr(rd_addr_q, LAST_ADDR);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge mgmt_clk_or_mgmt_cs_n or posedge rst) begin
    if (rst) begin
      state_q      <= ST_CMD;
      bit_cnt_q    <= 3'd0;
      rx_shift_q   <= 7'd0;
      dummy_cnt_q  <= 2'd0;
      burst_q      <= 1'b0;
      tx_shift_q   <= 8'h00;
      rd_addr_q    <= 8'h00;
      rd_en_q      <= 1'b0;
      byte_count_q <= 8'h00;
      cmd_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      dummy_cnt_q  <= dummy_cnt_d;
      burst_q      <= burst_d;
      tx_shift_q   <= tx_shift_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      byte_count_q <= byte_count_d;
      cmd_error_q  <= cmd_error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // MISO is gated by state so it reads 0 outside the data phase, including
  // immediately on reset or CS release.
  assign mgmt_miso  = (state_q == ST_SHIFT) & tx_shift_q[7];
  assign rd_addr    = rd_addr_q;
  assign rd_en      = rd_en_q;
  assign byte_count = byte_count_q;
  assign cmd_error  = cmd_error_q;

endmodule

// File: doc/mgmt_readback_tx.md
MGMT_READBACK_TX -- requirements
Module: mgmt_readback_tx

Interface
REQ-001 SHALL have parameter NUM_REGS, default 14, meaning the number of readable registers at addresses 0x00..NUM_REGS-1.
REQ-002 SHALL have parameter DUMMY_BYTES, default 1, meaning the number of turnaround bytes between the address byte and the first data byte; legal values are 1..3.
REQ-003 SHALL have port mgmt_clk_or_mgmt_cs_n, input, 1 bit: the block clock; all flops use its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port mgmt_cs_n, input, 1 bit: SPI chip select level, active low; a clock edge with mgmt_cs_n=1 is a CS-release edge.
REQ-006 SHALL have port mgmt_mosi, input, 1 bit: serial command and address, MSB first.
REQ-007 SHALL have port mgmt_miso, output, 1 bit: serial read data, MSB first.
REQ-008 SHALL have port rd_addr, output, 8 bits: registered register-file read address.
REQ-009 SHALL have port rd_data, input, 8 bits: combinational register-file value at rd_addr.
REQ-010 SHALL have port rd_en, output, 1 bit: one-clock pulse marking the edge on which rd_data is captured.
REQ-011 SHALL have port byte_count, output, 8 bits: data bytes loaded in the current or last transaction, saturating at 0xFF.
REQ-012 SHALL have port cmd_error, output, 1 bit: unsupported command seen; sticky until the next transaction's first edge.

Function
REQ-013 SHALL decode command 0x03 as a single read and command 0x0B as a burst read; every other command byte selects state IGNORE and sets cmd_error.
REQ-014 SHALL use states CMD, ADDR, DUMMY, SHIFT and IGNORE with a 3-bit bit counter; each byte completes on the 8th rising edge, with the assembled byte = {shift[6:0], mgmt_mosi}.
REQ-015 SHALL perform these transitions: CMD->ADDR on a valid command; ADDR->DUMMY, loading rd_addr with the assembled address; DUMMY->SHIFT after DUMMY_BYTES bytes; SHIFT stays in SHIFT; IGNORE stays in IGNORE.
REQ-016 SHALL, on the final edge of the last dummy byte and then on the final edge of each SHIFT byte in burst mode, load tx_shift with rd_data (0xFF if rd_addr>=NUM_REGS), pulse rd_en, increment byte_count and advance rd_addr.
REQ-017 SHALL advance rd_addr by wrapping NUM_REGS-1 to 0x00; an out-of-range start address increments unwrapped until 0xFF, then wraps to 0x00.
REQ-018 SHALL, in single-read mode, load only the first data byte; subsequent bytes load 0x00 and rd_addr is held.
REQ-019 SHALL drive mgmt_miso = tx_shift[7] in SHIFT and 0 in all other states, and shift tx_shift left by one (zero fill) on non-final SHIFT edges. Each bit is valid from one rising edge to the next, so the host samples on the falling edge (CPOL0/CPHA1).
REQ-020 SHALL give read latency as: data MSB appears after rising edge 8*(2+DUMMY_BYTES), which is edge 24 for the default.
REQ-021 SHALL, on a CS-release edge, force CMD, zero the bit counter and tx_shift, and deassert rd_en, while holding byte_count, cmd_error and rd_addr.
REQ-022 SHALL, on the first edge with mgmt_cs_n=0 in CMD with bit count 0, clear byte_count and cmd_error.
REQ-023 SHALL, when CS is released mid-byte, discard the partial byte; the next transaction starts clean in CMD.

Reset
REQ-024 SHALL, on rst=1, immediately set state=CMD and force the bit counter, tx_shift, rd_addr, rd_en, byte_count, cmd_error and mgmt_miso to 0.
REQ-025 SHALL hold reset values until the first rising edge after rst deasserts; a reset asserted mid-transaction aborts it, and the host must release and reassert CS.

Structure
REQ-026 SHALL place the command codes 0x03/0x0B, the state encoding and the register address map in the shared mgmt package used by the SPI configuration slave.
REQ-027 SHALL be a single module without sub-modules; the register-file mux stays outside, in the configuration register owner.

Verification
REQ-028 SHALL verify: CS low, send 0x03, 0x0C, dummy 0x00, 8 clocks with rd_data=0xA5 -> MISO bits 1,0,1,0,0,1,0,1, rd_addr=0x0C, byte_count=1.
REQ-029 SHALL verify: 0x0B, start address 0x0C, 3 data bytes with register model -> bytes from 0x0C, 0x0D, 0x00 (wrap), rd_en pulses=3, byte_count=3.
REQ-030 SHALL verify: 0x03, address 0x20 -> MISO byte 0xFF; second byte 0x00.
REQ-031 SHALL verify: command 0x5A -> cmd_error=1, MISO=0 throughout, rd_en never pulses; next valid transaction clears cmd_error.
REQ-032 SHALL verify: CS released after 5 bits of the address byte, then a fresh 0x03/0x01 read -> correct register 0x01 value, no stale data.
REQ-033 SHALL verify: rst pulsed during SHIFT -> mgmt_miso=0 and byte_count=0 immediately; a post-reset transaction operates normally.
